cordic_rotation_iter: RTL and testbench

CORDIC_ROTATION_ITER -- requirements
Module: cordic_rotation_iter

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_atan_rom.sv | 13 +
 rtl/cordic_rotation_iter.sv | 125 ++++++++++++
 tb/tb_cordic_rotation_iter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, angle constants and the arctangent table (Q16.16).
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PI     = 205887;
  localparam int PI_2   = 102944;
  localparam int ATAN_N = 16;

  // atan(2^-idx) in Q16.16
  function automatic int atan_lookup(input logic [3:0] idx);
    int v;
    case (idx)
      4'd0:    v = 51472;
      4'd1:    v = 30386;
      4'd2:    v = 16055;
      4'd3:    v = 8150;
      4'd4:    v = 4091;
      4'd5:    v = 2047;
      4'd6:    v = 1024;
      4'd7:    v = 512;
      4'd8:    v = 256;
      4'd9:    v = 128;
      4'd10:   v = 64;
      4'd11:   v = 32;
      4'd12:   v = 16;
      4'd13:   v = 8;
      4'd14:   v = 4;
      default: v = 2;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: micro-rotation index -> atan(2^-i), sign-extended to W bits.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = 32
) (
  input  logic        [3:0]   idx_i,
  output logic signed [W-1:0] atan_o
);

  assign atan_o = W'(atan_lookup(idx_i));

endmodule

// File: rtl/cordic_rotation_iter.sv
// Iterative CORDIC in rotation mode: one micro-rotation per clock, ready/valid on both sides.
// Outputs are unscaled (gain ~1.6468); neg_out tells the downstream scaler to negate.
module cordic_rotation_iter
  import cordic_pkg::*;
#(
  parameter  int INT_SIZE   = 16,
  parameter  int FRAC_SIZE  = 16,
  parameter  int ITERATIONS = 16,
  localparam int W          = INT_SIZE + FRAC_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic                neg_out
);

  localparam logic signed [W-1:0] PI_W     = W'(PI);
  localparam logic signed [W-1:0] PI_2_W   = W'(PI_2);
  localparam logic        [3:0]   LAST_IDX = 4'(ITERATIONS - 1);

  state_e              state_q, state_d;
  logic        [3:0]   i_q, i_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] z_q, z_d;
  logic                neg_q, neg_d;

  logic signed [W-1:0] x_sh, y_sh, atan_w;

  cordic_atan_rom #(.W(W)) u_atan_rom (
    .idx_i  (i_q),
    .atan_o (atan_w)
  );

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  // Next-state and datapath: load with quadrant fold, micro-rotate, hold for the handshake.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          i_d     = 4'd0;
          state_d = ITER;
          // Fold angles outside [-pi/2, pi/2] by pi; the result then needs negation.
          if (z_in > PI_2_W) begin
            z_d   = z_in - PI_W;
            neg_d = 1'b1;
          end else if (z_in < -PI_2_W) begin
            z_d   = z_in + PI_W;
            neg_d = 1'b1;
          end else begin
            z_d   = z_in;
            neg_d = 1'b0;
          end
        end
      end
      ITER: begin
        if (!z_q[W-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_w;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_w;
        end
        i_d = i_q + 4'd1;
        if (i_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 4'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign neg_out   = neg_q;

endmodule

// File: tb/tb_cordic_rotation_iter.sv
// Directed bench for cordic_rotation_iter: reset, angle vectors, handshake, mid-run reset, back-to-back.
module tb_cordic_rotation_iter;

  localparam int W   = 32;
  localparam int TOL = 16;
  localparam int GX  = 107922;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out, y_out;
  logic                neg_out;

  int n_vec  = 0;
  int n_miss = 0;

  cordic_rotation_iter #(.INT_SIZE(16), .FRAC_SIZE(16), .ITERATIONS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .neg_out   (neg_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit near(input logic signed [W-1:0] a, input int e);
    int d;
    d = int'(a) - e;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    #3;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_miss++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_vec++;
    if (x_out !== 0 || y_out !== 0 || neg_out !== 1'b0) begin
      n_miss++; $display("FAIL reset_data: x=%0d y=%0d neg=%b want 0/0/0", x_out, y_out, neg_out);
    end
    tick(); tick();
    rst_n = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int vx[5]  = '{65536, 65536, 65536, 65536, 65536};
    int vz[5]  = '{0, 102944, 205887, -102944, -205887};
    int ex[5]  = '{GX, 0, GX, 0, GX};
    int ey[5]  = '{0, GX, 0, -GX, 0};
    bit en[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int edges;
    for (int v = 0; v < 5; v++) begin
      x_in = vx[v]; y_in = 0; z_in = vz[v]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      edges = 1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_miss++; $display("FAIL dir%0d_busy: in_ready=%b want 0", v, in_ready);
      end
      while (!out_valid && edges < 40) begin
        tick();
        edges++;
      end
      n_vec++;
      if (edges !== 17) begin
        n_miss++; $display("FAIL dir%0d_latency: edges=%0d want 17", v, edges);
      end
      n_vec++;
      if (!near(x_out, ex[v]) || !near(y_out, ey[v]) || neg_out !== en[v]) begin
        n_miss++;
        $display("FAIL dir%0d_result: x=%0d y=%0d neg=%b want %0d %0d %b (+-%0d)",
                 v, x_out, y_out, neg_out, ex[v], ey[v], en[v], TOL);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_miss++; $display("FAIL dir%0d_xfer: out_valid=%b in_ready=%b want 0/1", v, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_handshake();
    logic signed [W-1:0] hx, hy;
    int edges;
    x_in = 65536; y_in = 0; z_in = 0; in_valid = 1'b1;
    tick();
    // Alternate operand presented during ITER and DONE must be ignored.
    x_in = 0; y_in = 65536; z_in = 0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      in_valid = edges[0];
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_miss++; $display("FAIL hs_iter_ready: edge %0d in_ready=%b want 0", edges, in_ready);
      end
      tick();
      edges++;
    end
    n_vec++;
    if (!out_valid || !near(x_out, GX) || !near(y_out, 0)) begin
      n_miss++; $display("FAIL hs_result: valid=%b x=%0d y=%0d want 1 %0d 0", out_valid, x_out, y_out, GX);
    end
    hx = x_out; hy = y_out;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== hx || y_out !== hy || neg_out !== 1'b0) begin
        n_miss++;
        $display("FAIL hs_hold%0d: valid=%b rdy=%b x=%0d y=%0d want 1 0 %0d %0d", c, out_valid, in_ready, x_out, y_out, hx, hy);
      end
    end
    // in_valid stays high across the transfer: no same-edge acceptance.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_miss++; $display("FAIL hs_after_xfer: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_miss++; $display("FAIL hs_accept_next: in_ready=%b want 0", in_ready);
    end
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    n_vec++;
    if (!out_valid || !near(x_out, 0) || !near(y_out, GX)) begin
      n_miss++; $display("FAIL hs_second: valid=%b x=%0d y=%0d want 1 0 %0d", out_valid, x_out, y_out, GX);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int edges;
    x_in = 65536; y_in = 0; z_in = 205887; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_miss++; $display("FAIL mid_rst_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_vec++;
    if (x_out !== 0 || y_out !== 0 || neg_out !== 1'b0) begin
      n_miss++; $display("FAIL mid_rst_data: x=%0d y=%0d neg=%b want 0/0/0", x_out, y_out, neg_out);
    end
    tick();
    rst_n = 1'b1;
    x_in = 65536; y_in = 0; z_in = -102944; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    n_vec++;
    if (edges !== 17 || !near(x_out, 0) || !near(y_out, -GX) || neg_out !== 1'b0) begin
      n_miss++;
      $display("FAIL mid_rst_fresh: edges=%0d x=%0d y=%0d neg=%b want 17 0 %0d 0", edges, x_out, y_out, neg_out, -GX);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int oz[3] = '{0, 102944, 205887};
    int ex[3] = '{GX, 0, GX};
    int ey[3] = '{0, GX, 0};
    bit en[3] = '{1'b0, 1'b0, 1'b1};
    int acc = 0;
    int res = 0;
    int last = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in = 65536; y_in = 0; z_in = oz[0];
    for (int cyc = 0; cyc < 100 && res < 3; cyc++) begin
      if (in_ready) begin
        if (acc < 3) begin
          x_in = 65536; y_in = 0; z_in = oz[acc];
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      if (out_valid) begin
        n_vec++;
        if (!near(x_out, ex[res]) || !near(y_out, ey[res]) || neg_out !== en[res]) begin
          n_miss++;
          $display("FAIL b2b%0d_result: x=%0d y=%0d neg=%b want %0d %0d %b", res, x_out, y_out, neg_out, ex[res], ey[res], en[res]);
        end
        if (res > 0) begin
          n_vec++;
          if (cyc - last !== 18) begin
            n_miss++; $display("FAIL b2b%0d_spacing: got %0d cycles want 18", res, cyc - last);
          end
        end
        last = cyc;
        res++;
      end
    end
    n_vec++;
    if (res !== 3) begin
      n_miss++; $display("FAIL b2b_count: got %0d results want 3", res);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
